exp_engine_arbiter: RTL and testbench

//  Shares one exponent engine (start/done handshake) among NREQ requesters.

---
 rtl/exp_engine_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_exp_engine_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_engine_arbiter.sv
// Round-robin arbiter sharing one exponent engine (start/done handshake) among NREQ requesters.
// Optional build macro EXP_ARB_TIMEOUT_EN adds a WAIT watchdog and the err output.
module exp_engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int RW      = 16,
  parameter int GW      = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] x_in,
  output logic [NREQ-1:0]    ack,
  output logic [RW-1:0]      result,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               exp_start,
  output logic [DW-1:0]      exp_x,
  input  logic               exp_done,
  input  logic [RW-1:0]      exp_result
`ifdef EXP_ARB_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DELIVER
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [RW-1:0]     result_q, result_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [DW-1:0]     x_q, x_d;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  logic [GW-1:0]     winner;
  logic              found;
  logic [DW-1:0]     lane_x;
  logic [NREQ-1:0]   grant_oh;
  logic [GW-1:0]     ptr_next;

  // Two passes give the wrap-around search: lanes at/above the pointer first, then the rest.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (GW'(j) >= ptr_q)) begin
        found  = 1'b1;
        winner = GW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        found  = 1'b1;
        winner = GW'(j);
      end
    end
  end

  always_comb begin
    lane_x   = '0;
    grant_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (winner == GW'(j)) lane_x = x_in[j*DW +: DW];
      grant_oh[j] = (grant_q == GW'(j));
    end
    ptr_next = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack_d    = '0;
    result_d = result_q;
    grant_d  = grant_q;
    start_d  = 1'b0;
    x_d      = x_q;
`ifdef EXP_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_LOAD;
          grant_d = winner;
          x_d     = lane_x;
        end
      end
      S_LOAD: begin
        state_d = S_START;
        start_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef EXP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (exp_done) begin
          state_d  = S_DELIVER;
          result_d = exp_result;
          ack_d    = grant_oh;
        end
`ifdef EXP_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d  = S_DELIVER;
          result_d = '0;
          ack_d    = grant_oh;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DELIVER: begin
        state_d = S_IDLE;
        ptr_d   = ptr_next;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      ack_q    <= '0;
      result_q <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      x_q      <= '0;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      x_q      <= x_d;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign result    = result_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign exp_start = start_q;
  assign exp_x     = x_q;
`ifdef EXP_ARB_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Directed bench for exp_engine_arbiter with a behavioural exponent-engine stub.
module tb_exp_engine_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int RW   = 16;
  localparam int GW   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] x_in;
  logic [NREQ-1:0]    ack;
  logic [RW-1:0]      result;
  logic [GW-1:0]      grant_id;
  logic               busy;
  logic               exp_start;
  logic [DW-1:0]      exp_x;
  logic               exp_done;
  logic [RW-1:0]      exp_result;
`ifdef EXP_ARB_TIMEOUT_EN
  logic               err;
`endif

  int checks   = 0;
  int failures = 0;

  int          start_cnt = 0;
  int          ack_cnt   = 0;
  logic [15:0] start_x   = '0;

  int          eng_delay = 5;
  logic        eng_never = 1'b0;
  logic        eng_fixed = 1'b0;
  logic [15:0] eng_res   = '0;

  exp_engine_arbiter #(
    .NREQ(NREQ), .DW(DW), .RW(RW), .GW(GW), .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .x_in(x_in),
    .ack(ack),
    .result(result),
    .grant_id(grant_id),
    .busy(busy),
    .exp_start(exp_start),
    .exp_x(exp_x),
    .exp_done(exp_done),
    .exp_result(exp_result)
`ifdef EXP_ARB_TIMEOUT_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_start === 1'b1) begin
      start_cnt++;
      start_x = exp_x;
    end
    if (ack !== '0) ack_cnt++;
  end

  // Engine stub: done pulse eng_delay cycles after it sees start; abandons the job on reset.
  initial begin
    int k;
    exp_done   = 1'b0;
    exp_result = '0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_start === 1'b1 && !eng_never) begin
        k = 1;
        while (k < eng_delay && !rst) begin
          @(negedge clk);
          #2;
          k++;
        end
        if (!rst) begin
          exp_done   = 1'b1;
          exp_result = eng_fixed ? eng_res : (exp_x ^ 16'h5A00);
          @(negedge clk);
          #2;
          exp_done   = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (ack == '0 && cyc < 300) begin
      tick();
      cyc++;
    end
    check_eq("ack_seen", {63'b0, ack != '0}, 64'd1);
  endtask

  task automatic wait_start(input int s0);
    int n;
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      tick();
      n++;
    end
    check_eq("start_seen", {63'b0, start_cnt != s0}, 64'd1);
  endtask

  task automatic serve(input int lane, input logic [15:0] expres);
    int cyc;
    wait_ack(cyc);
    check_eq($sformatf("ack_lane%0d", lane), ack, 64'd1 << lane);
    check_eq($sformatf("result_lane%0d", lane), result, expres);
    check_eq($sformatf("grant_lane%0d", lane), grant_id, lane);
    req[lane] = 1'b0;
    tick();
    check_eq($sformatf("ack_pulse_lane%0d", lane), ack, 0);
  endtask

  initial begin
    int s0;
    int a0;
    int cyc;
    rst  = 1'b1;
    req  = '0;
    x_in = '0;
    repeat (3) tick();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) tick();
    check_eq("idle_ack", ack, 0);
    check_eq("idle_result", result, 0);
    check_eq("idle_grant", grant_id, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_start", exp_start, 0);
    check_eq("idle_expx", exp_x, 0);
    check_eq("idle_start_cnt", start_cnt, 0);

    // Single request on lane 0; operand changes after start must not reach the engine.
    eng_fixed = 1'b1;
    eng_res   = 16'h0014;
    eng_delay = 5;
    x_in[15:0] = 16'd3;
    s0  = start_cnt;
    req = 4'b0001;
    wait_start(s0);
    check_eq("start_x", start_x, 16'd3);
    check_eq("busy_op", busy, 1);
    x_in[15:0] = 16'hAAAA;
    wait_ack(cyc);
    check_eq("t2_ack", ack, 4'b0001);
    check_eq("t2_result", result, 16'h0014);
    check_eq("t2_expx_frozen", exp_x, 16'd3);
    check_eq("t2_one_start", start_cnt - s0, 1);
    req = '0;
    tick();
    check_eq("t2_ack_once", ack, 0);
    check_eq("t2_busy_done", busy, 0);
    check_eq("t2_result_held", result, 16'h0014);

    // Clear the pointer, then all four lanes at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    eng_fixed = 1'b0;
    eng_delay = 3;
    x_in = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    req  = 4'b1111;
    serve(0, 16'h5A10);
    serve(1, 16'h5A11);
    serve(2, 16'h5A12);
    serve(3, 16'h5A13);
    check_eq("rr_result_held", result, 16'h5A13);

    // After lane 0, a 1001 request must favour lane 3.
    req = 4'b0001;
    serve(0, 16'h5A10);
    req = 4'b1001;
    serve(3, 16'h5A13);
    serve(0, 16'h5A10);

    // Reset in the middle of WAIT aborts without an ack.
    eng_delay = 20;
    s0  = start_cnt;
    req = 4'b0100;
    wait_start(s0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_start", exp_start, 0);
    check_eq("abort_ack", ack, 0);
    check_eq("abort_grant", grant_id, 0);
    a0  = ack_cnt;
    req = '0;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    check_eq("abort_no_ack", ack_cnt - a0, 0);
    check_eq("abort_idle", busy, 0);
    eng_delay = 3;
    req = 4'b0010;
    serve(1, 16'h5A11);

`ifdef EXP_ARB_TIMEOUT_EN
    // Engine never answers: watchdog delivers result 0 with err after 64 WAIT cycles.
    eng_never = 1'b1;
    s0  = start_cnt;
    req = 4'b0001;
    wait_start(s0);
    wait_ack(cyc);
    check_eq("to_cycles", cyc, 65);
    check_eq("to_ack", ack, 4'b0001);
    check_eq("to_err", err, 1);
    check_eq("to_result", result, 0);
    req = '0;
    tick();
    check_eq("to_err_once", err, 0);
    eng_never = 1'b0;
    req = 4'b0100;
    serve(2, 16'h5A12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
